// File: rtl/qiangda_n.sv
// qiangda_n -- N-player quiz buzzer controller.
//
// The host arms a round with clr_n. An arming countdown then runs, and the
// first valid press wins the round. After that, an answer countdown runs.
// Countdown seconds come from an internal prescaler on clk100khz.
//
// Outputs:
//   - a one-hot winner LED bank
//   - winner and foul ids
//   - a 6-slot multiplexed 7-segment display
//
// Optional feature (macro QIANGDA_FOUL_DETECT_EN):
//   A press while idle records a foul player. That player is masked for the
//   next round. Slot 4 of the display shows the foul digit.
//
// Ports:
//   clk100khz  in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   clr_n      in   host control: low = clear/hold, high = run (async, synced)
//   btn_n      in   player buttons, active-low (async, synced)
//   led        out  one-hot winner, led[i] = player i+1
//   winner     out  winning player id, 0 = none
//   foul       out  early-press player id, 0 = none
//   time_up    out  high while the round is done
//   scan       out  digit select
//   dout       out  7-segment pattern {dp,g..a}, active-high
module qiangda_n #(
  parameter int N_PLAYERS   = 4,
  parameter int TICK_DIV    = 100000,
  parameter int ARM_SECS    = 5,
  parameter int ANSWER_SECS = 30
) (
  input  logic                 clk100khz,
  input  logic                 reset,
  input  logic                 clr_n,
  input  logic [N_PLAYERS-1:0] btn_n,
  output logic [N_PLAYERS-1:0] led,
  output logic [3:0]           winner,
  output logic [3:0]           foul,
  output logic                 time_up,
  output logic [5:0]           scan,
  output logic [7:0]           dout
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] ANSWER = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [3:0] ARM_T = 4'(ARM_SECS / 10);
  localparam logic [3:0] ARM_O = 4'(ARM_SECS % 10);
  localparam logic [3:0] ANS_T = 4'(ANSWER_SECS / 10);
  localparam logic [3:0] ANS_O = 4'(ANSWER_SECS % 10);

  logic [1:0]           state;
  logic [PW-1:0]        presc;
  logic [3:0]           cnt_tens, cnt_ones;
  logic [2:0]           slot;
  logic                 clr_s1, clr_s;
  logic [N_PLAYERS-1:0] btn_s1, btn_s;
  logic [N_PLAYERS-1:0] mask, press, oh;
  logic [3:0]           idx;
  logic                 hit, tick, cnt_zero;

  // Two-flop synchronisers. Buttons reset to "released"; clr resets to "hold".
  always_ff @(posedge clk100khz) begin
    if (reset) begin
      clr_s1 <= 1'b0;
      clr_s  <= 1'b0;
      btn_s1 <= '1;
      btn_s  <= '1;
    end else begin
      clr_s1 <= clr_n;
      clr_s  <= clr_s1;
      btn_s1 <= btn_n;
      btn_s  <= btn_s1;
    end
  end

  assign press = ~btn_s & ~mask;

  // Lowest index wins. Scanning downward lets the last hit be the lowest index.
  always_comb begin
    hit = 1'b0;
    idx = 4'd0;
    oh  = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (press[i]) begin
        hit   = 1'b1;
        idx   = 4'(i);
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
  end

`ifdef QIANGDA_FOUL_DETECT_EN
  logic [3:0] foul_q;

  // The mask is zero while foul_q is zero, so in IDLE the encoder sees every press.
  always_ff @(posedge clk100khz) begin
    if (reset)
      foul_q <= 4'd0;
    else if (state != IDLE && !clr_s)
      foul_q <= 4'd0;
    else if (state == IDLE && foul_q == 4'd0 && hit)
      foul_q <= idx + 4'd1;
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < N_PLAYERS; i++)
      mask[i] = (foul_q == 4'(i + 1));
  end

  assign foul = foul_q;
`else
  assign mask = '0;
  assign foul = 4'd0;
`endif

  assign tick     = (presc == PW'(TICK_DIV - 1));
  assign cnt_zero = (cnt_tens == 4'd0) && (cnt_ones == 4'd0);
  assign time_up  = (state == DONE);

  always_ff @(posedge clk100khz) begin
    if (reset) begin
      state    <= IDLE;
      led      <= '0;
      winner   <= 4'd0;
      cnt_tens <= ARM_T;
      cnt_ones <= ARM_O;
      presc    <= '0;
      slot     <= 3'd0;
    end else begin
      slot  <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
      presc <= tick ? '0 : presc + PW'(1);
      if (state != IDLE && !clr_s) begin
        // Clear takes priority over every other event in the same cycle.
        state    <= IDLE;
        presc    <= '0;
        led      <= '0;
        winner   <= 4'd0;
        cnt_tens <= ARM_T;
        cnt_ones <= ARM_O;
      end else begin
        case (state)
          IDLE: if (clr_s) begin
            state    <= ARMED;
            presc    <= '0;
            cnt_tens <= ARM_T;
            cnt_ones <= ARM_O;
          end
          ARMED: if (hit) begin
            // A press beats the 00 timeout in the same cycle.
            state    <= ANSWER;
            presc    <= '0;
            winner   <= idx + 4'd1;
            led      <= oh;
            cnt_tens <= ANS_T;
            cnt_ones <= ANS_O;
          end else if (tick) begin
            if (cnt_zero) begin
              state <= DONE;
              presc <= '0;
            end else if (cnt_ones == 4'd0) begin
              cnt_ones <= 4'd9;
              cnt_tens <= cnt_tens - 4'd1;
            end else begin
              cnt_ones <= cnt_ones - 4'd1;
            end
          end
          ANSWER: if (tick) begin
            if (cnt_zero) begin
              state <= DONE;
              presc <= '0;
            end else if (cnt_ones == 4'd0) begin
              cnt_ones <= 4'd9;
              cnt_tens <= cnt_tens - 4'd1;
            end else begin
              cnt_ones <= cnt_ones - 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 8'h3F;  4'h1: seg = 8'h06;  4'h2: seg = 8'h5B;  4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;  4'h5: seg = 8'h6D;  4'h6: seg = 8'h7D;  4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;  4'h9: seg = 8'h6F;  4'hA: seg = 8'h77;  4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;  4'hD: seg = 8'h5E;  4'hE: seg = 8'h79;  default: seg = 8'h71;
    endcase
  endfunction

  logic [3:0] dig;
  logic       dig_en;

  always_comb begin
    scan   = 6'b000000;
    dig    = 4'd0;
    dig_en = 1'b0;
    case (slot)
      3'd1: begin scan = 6'b000100; dig = winner;   dig_en = 1'b1; end
      3'd2: begin scan = 6'b010000; dig = cnt_ones; dig_en = 1'b1; end
      3'd3: begin scan = 6'b100000; dig = cnt_tens; dig_en = 1'b1; end
`ifdef QIANGDA_FOUL_DETECT_EN
      3'd4: begin scan = 6'b000001; dig = foul;     dig_en = 1'b1; end
`endif
      default: ;
    endcase
    dout = dig_en ? seg(dig) : 8'h00;
  end

endmodule

// File: tb/tb_qiangda_n.sv
module tb_qiangda_n;
  logic       clk = 1'b0;
  logic       reset, clr_n;
  logic [5:0] btn_n, led, scan;
  logic [3:0] winner, foul;
  logic       time_up;
  logic [7:0] dout;
  int n_chk = 0, n_fail = 0;

  qiangda_n #(.N_PLAYERS(6), .TICK_DIV(4), .ARM_SECS(3), .ANSWER_SECS(12)) dut (
    .clk100khz(clk), .reset(reset), .clr_n(clr_n), .btn_n(btn_n), .led(led),
    .winner(winner), .foul(foul), .time_up(time_up), .scan(scan), .dout(dout));

  always #5 clk = ~clk;

`ifdef QIANGDA_FOUL_DETECT_EN
  localparam bit FD = 1'b1;
`else
  localparam bit FD = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt();
    return {24'd0, dut.cnt_tens, dut.cnt_ones};
  endfunction

  function automatic logic [31:0] bcd(input int v);
    return {24'd0, 4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cnt_change(output int cyc);
    logic [31:0] prev;
    prev = cnt();
    cyc  = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (cnt() != prev) begin cyc = i; break; end
    end
  endtask

  task automatic wait_time_up(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (time_up === 1'b1) begin cyc = i; break; end
    end
  endtask

  // Leaves the bench at the first negedge after ARMED is entered.
  task automatic arm();
    clr_n = 1'b0; btn_n = '1; step(3);
    clr_n = 1'b1; step(3);
  endtask

  // Over one full slot sweep in DONE, count the blank slots.
  // A blank slot must also drive dout = 0.
  task automatic blank_sweep();
    int zeros, bad;
    zeros = 0; bad = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (scan == 6'd0) begin zeros++; if (dout != 8'h00) bad++; end
    end
    chk("blank slots", zeros, FD ? 2 : 3);
    chk("blank dout", bad, 0);
  endtask

  typedef struct {
    logic [5:0] btn;
    logic [5:0] late;
    logic [3:0] exp_w;
    logic [5:0] exp_led;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int cyc;
    bit found;
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit found;
    tbl[0] = '{6'b111011, 6'b111110, 4'd3, 6'b000100};
    tbl[1] = '{6'b101101, 6'b101111, 4'd2, 6'b000010};
    tbl[2] = '{6'b011111, 6'b111101, 4'd6, 6'b100000};
    tbl[3] = '{6'b111110, 6'b011111, 4'd1, 6'b000001};
    tbl[4] = '{6'b000000, 6'b111111, 4'd1, 6'b000001};

    // Reset state
    reset = 1'b1; clr_n = 1'b0; btn_n = '1;
    step(2);
    chk("rst led", led, 0);
    chk("rst winner", winner, 0);
    chk("rst foul", foul, 0);
    chk("rst time_up", time_up, 0);
    chk("rst count", cnt(), bcd(3));
    chk("rst scan", scan, 0);
    chk("rst dout", dout, 0);
    reset = 1'b0;

    // Table: first press wins, ties go to the lowest index, later presses are ignored
    for (int r = 0; r < 5; r++) begin
      arm();
      btn_n = tbl[r].btn;
      step(2);
      chk($sformatf("row%0d latency", r), winner, 0);
      step(1);
      chk($sformatf("row%0d winner", r), winner, tbl[r].exp_w);
      chk($sformatf("row%0d led", r), led, tbl[r].exp_led);
      chk($sformatf("row%0d count", r), cnt(), bcd(12));
      btn_n = tbl[r].late;
      step(4);
      chk($sformatf("row%0d late winner", r), winner, tbl[r].exp_w);
      chk($sformatf("row%0d late led", r), led, tbl[r].exp_led);
    end

    // Scenario 1 + display sweep: time the press so ANSWER entry lands on slot 1
    arm();
    chk("s1 armed count", cnt(), bcd(3));
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (scan == 6'b100000) begin found = 1'b1; break; end
      step(1);
    end
    chk("s1 slot3 seen", found, 1);
    step(1);
    btn_n = 6'b111011;
    step(3);
    chk("s1 winner", winner, 3);
    chk("s1 led", led, 6'b000100);
    chk("s1 count12", cnt(), bcd(12));
    chk("s6 scan1", scan, 6'b000100);
    chk("s6 dout1", dout, 8'h4F);
    step(1);
    chk("s6 scan2", scan, 6'b010000);
    chk("s6 dout2", dout, 8'h5B);
    step(1);
    chk("s6 scan3", scan, 6'b100000);
    chk("s6 dout3", dout, 8'h06);
    step(1);
    chk("s6 scan4", scan, FD ? 6'b000001 : 6'b000000);
    chk("s6 dout4", dout, FD ? 8'h3F : 8'h00);
    btn_n = '1;
    step(1);
    chk("s1 count11", cnt(), bcd(11));
    for (int v = 10; v >= 0; v--) begin
      wait_cnt_change(cyc);
      chk($sformatf("s1 period %0d", v), cyc, 4);
      chk($sformatf("s1 count %0d", v), cnt(), bcd(v));
    end
    wait_time_up(cyc);
    chk("s1 done delay", cyc, 4);
    chk("s1 done winner", winner, 3);
    chk("s1 done led", led, 6'b000100);
    btn_n = 6'b111110;
    step(5);
    chk("s1 done press ignored", winner, 3);
    btn_n = '1;

    // Scenario 3: no press in ARMED
    arm();
    chk("s3 count3", cnt(), bcd(3));
    for (int v = 2; v >= 0; v--) begin
      wait_cnt_change(cyc);
      chk($sformatf("s3 period %0d", v), cyc, 4);
      chk($sformatf("s3 count %0d", v), cnt(), bcd(v));
    end
    wait_time_up(cyc);
    chk("s3 done delay", cyc, 4);
    chk("s3 winner", winner, 0);
    chk("s3 led", led, 0);
    blank_sweep();

    // Scenario 4: clear mid-ANSWER, then reset mid-ARMED
    arm();
    btn_n = 6'b111110;
    step(3);
    chk("s4 winner", winner, 1);
    btn_n = '1;
    step(2);
    clr_n = 1'b0;
    step(2);
    chk("s4 clr latency", winner, 1);
    step(1);
    chk("s4 clr winner", winner, 0);
    chk("s4 clr led", led, 0);
    chk("s4 clr count", cnt(), bcd(3));
    chk("s4 clr time_up", time_up, 0);
    clr_n = 1'b1;
    step(3);
    step(5);
    chk("s4 armed count", cnt(), bcd(2));
    reset = 1'b1;
    step(1);
    chk("s4 rst count", cnt(), bcd(3));
    chk("s4 rst winner", winner, 0);
    chk("s4 rst led", led, 0);
    chk("s4 rst foul", foul, 0);
    chk("s4 rst time_up", time_up, 0);
    chk("s4 rst scan", scan, 0);
    chk("s4 rst dout", dout, 0);
    reset = 1'b0; clr_n = 1'b0;

    // Scenario 5: early press, then a round with buttons held as ARMED begins
    btn_n = 6'b111110;
    step(3);
    chk("s5 foul", foul, FD ? 1 : 0);
    btn_n = 6'b110110;
    step(2);
    clr_n = 1'b1;
    step(4);
    chk("s5 winner", winner, FD ? 4 : 1);
    chk("s5 led", led, FD ? 6'b001000 : 6'b000001);
    chk("s5 foul held", foul, FD ? 1 : 0);
    btn_n = '1; clr_n = 1'b0;
    step(3);
    chk("s5 foul cleared", foul, 0);
    chk("s5 winner cleared", winner, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
